sdr_cmd_monitor: RTL
====================

SDR_CMD_MONITOR -- requirements
Module: sdr_cmd_monitor

Interface
REQ-001 SHALL have parameter SDR_AW, default 13: SDRAM address width.
REQ-002 SHALL have parameter SDR_BA_W, default 2: bank-address width; NB = 2**SDR_BA_W banks.
REQ-003 SHALL have parameter TRCD, default 3: minimum cycles from ACT to READ/WRITE on the same bank.
REQ-004 SHALL have parameter TRP, default 3: minimum cycles from PRE to ACT on the same bank.
REQ-005 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-006 SHALL have port sdram_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port sdram_resetn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_cke, inputs, 1 each: sampled SDRAM command pins.
REQ-009 SHALL have ports sdr_ba (input, SDR_BA_W) and sdr_addr (input, SDR_AW): sampled bank and address.
REQ-010 SHALL have port err_clr, input, 1: clears sticky errors.
REQ-011 SHALL have port bank_open, output, NB: bit b high while bank b is in ACTIVE.
REQ-012 SHALL have port open_row, output, NB*SDR_AW: row latched per bank at ACT.
REQ-013 SHALL have port err, output, 6: sticky violation flags, bit map in REQ-024.
REQ-014 SHALL have port mode_bl, output, 3, and port mode_cl, output, 3: burst length and CAS latency from the last MRS.
REQ-015 SHALL have ports act_cnt, rd_cnt, wr_cnt, ref_cnt, outputs, CNT_W each: command counts.

Function
REQ-016 SHALL decode a command only when sdr_cke=1 and sdr_cs_n=0; otherwise treat the cycle as NOP.
REQ-017 SHALL decode {ras_n,cas_n,we_n}: 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 AREF, 000 MRS, 110 BST, 111 NOP.
REQ-018 SHALL treat PRE with sdr_addr[10]=1 as applying to all banks, else to bank sdr_ba.
REQ-019 SHALL run one FSM per bank with states IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-020 SHALL on ACT to an IDLE bank: go to ACTIVATING, load timer TRCD-1, latch sdr_addr into open_row; ACTIVATING goes to ACTIVE the cycle after the timer reaches 0.
REQ-021 SHALL on PRE to an ACTIVATING or ACTIVE bank: go to PRECHARGING, load timer TRP-1; PRECHARGING goes to IDLE the cycle after the timer reaches 0.
REQ-022 SHALL treat PRE to an IDLE bank as legal with no state change, and PRE to a PRECHARGING bank as legal with the timer not reloaded.
REQ-023 SHALL on MRS latch mode_bl=sdr_addr[2:0] and mode_cl=sdr_addr[6:4].
REQ-024 SHALL set error bits as follows.
- err[0]: ACT to an ACTIVE bank.
- err[1]: ACT to a PRECHARGING bank (tRP violation).
- err[2]: READ/WRITE to an ACTIVATING bank (tRCD violation).
- err[3]: READ/WRITE to an IDLE or PRECHARGING bank.
- err[4]: AREF with any bank not IDLE.
- err[5]: MRS with any bank not IDLE.
REQ-025 SHALL leave bank state unchanged on an erroneous command, except err[0], which re-latches open_row.
REQ-026 SHALL hold err bits until err_clr; when err_clr coincides with a new violation, the new bit SHALL be set and all others cleared.
REQ-027 SHALL make outputs registered, reflecting a command one cycle after it is sampled.
REQ-028 SHALL increment counters by 1 per ACT, READ, WRITE, or AREF, including erroneous ones, saturating at all-ones.

Reset
REQ-029 SHALL on sdram_resetn=0, asynchronously and regardless of activity, force:
- all banks to IDLE, timers to 0;
- open_row, err, counters to 0;
- mode_bl and mode_cl to 0.
REQ-030 SHALL, when reset is released mid-burst, decode the first command on the first rising edge after release.

Configuration
REQ-031 SHALL, with SDR_MON_CNT_EN defined, implement the four counters and their increment logic.
REQ-032 SHALL, with SDR_MON_CNT_EN undefined, omit counter flops and drive act_cnt, rd_cnt, wr_cnt, ref_cnt to constant 0; all other behaviour is unchanged.

Structure
REQ-033 SHALL place the command enum, bank-state enum, and err bit-index constants in package sdr_mon_pkg.
REQ-034 SHALL implement the per-bank FSM and timer as sub-module sdr_mon_bank, instantiated NB times by generate.

Verification
REQ-035 SHALL cover: ACT b1 row 0x1A5, 3 NOPs, READ b1 -> bank_open[1]=1, open_row[1]=0x1A5, err=0.
REQ-036 SHALL cover: ACT b0, then READ b0 one cycle later, TRCD=3 -> err[2]=1, bank 0 reaches ACTIVE after 3 cycles.
REQ-037 SHALL cover: ACT b2, PRE all (addr[10]=1), ACT b2 next cycle -> err[1]=1; same ACT after TRP cycles -> no new error.
REQ-038 SHALL cover: bank 3 ACTIVE, AREF -> err[4]=1; err_clr coincident with WRITE to IDLE b0 -> err=6'b001000.
REQ-039 SHALL cover: MRS addr=0x032 with all banks IDLE -> mode_bl=2, mode_cl=3; CNT_W=4 with 20 ACT/PRE pairs -> act_cnt=15 (with SDR_MON_CNT_EN), 0 (without).
REQ-040 SHALL cover: sdram_resetn asserted mid-ACTIVATING -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sdr_mon_pkg.sv
// sdr_mon_pkg
// Shared definitions for the SDRAM command monitor.
// - sdr_cmd_e     : command encoding. Each enum value equals the {ras_n,cas_n,we_n} pin
//                   pattern, so decoding needs no lookup table.
// - bank_state_e  : states of the per-bank protocol tracker.
// - ERR_*         : bit positions inside the sticky err vector.
// - decode_cmd()  : turns the sampled command pins into a sdr_cmd_e.
package sdr_mon_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_AREF  = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } sdr_cmd_e;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    localparam int ERR_W          = 6;
    localparam int ERR_ACT_OPEN   = 0;  // ACT to a bank that is already ACTIVE
    localparam int ERR_TRP        = 1;  // ACT while the bank is still precharging
    localparam int ERR_TRCD       = 2;  // READ/WRITE while the bank is still activating
    localparam int ERR_RW_CLOSED  = 3;  // READ/WRITE to an idle or precharging bank
    localparam int ERR_AREF_OPEN  = 4;  // AREF while any bank is not idle
    localparam int ERR_MRS_OPEN   = 5;  // MRS while any bank is not idle

    // A deselected chip or a cycle with the clock disabled carries no command.
    function automatic sdr_cmd_e decode_cmd(input logic cke,
                                            input logic cs_n,
                                            input logic ras_n,
                                            input logic cas_n,
                                            input logic we_n);
        sdr_cmd_e c;
        c = CMD_NOP;
        if (cke && !cs_n) begin
            c = sdr_cmd_e'({ras_n, cas_n, we_n});
        end
        return c;
    endfunction

endpackage

// File: rtl/sdr_mon_bank.sv
// sdr_mon_bank
// Protocol tracker for a single SDRAM bank: a four-state FSM
// (IDLE -> ACTIVATING -> ACTIVE -> PRECHARGING -> IDLE) plus a down-counting timer
// that models tRCD and tRP, and the row address latched at ACT.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   act         : ACT command addressed to this bank this cycle
//   pre         : PRE command hitting this bank this cycle (single or all-bank)
//   row_in      : sampled address bus, latched as the open row on ACT
//   state       : current bank_state_e value (as 2 bits)
//   row         : row latched by the last accepted ACT
module sdr_mon_bank #(
    parameter int SDR_AW = 13,
    parameter int TRCD   = 3,
    parameter int TRP    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              act,
    input  logic              pre,
    input  logic [SDR_AW-1:0] row_in,
    output logic [1:0]        state,
    output logic [SDR_AW-1:0] row
);

    import sdr_mon_pkg::*;

    // Timer only ever holds TRCD-1 or TRP-1, so size it for the larger of the two.
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    bank_state_e       cur_state;
    bank_state_e       nxt_state;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nxt;
    logic [SDR_AW-1:0] row_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= BANK_IDLE;
            timer     <= '0;
            row       <= '0;
        end else begin
            cur_state <= nxt_state;
            timer     <= timer_nxt;
            row       <= row_nxt;
        end
    end

    // Illegal commands for the current state (ACT while activating or precharging)
    // are simply ignored here; the top flags them. The one exception is ACT to an
    // ACTIVE bank, which re-latches the row so open_row follows what the controller
    // believes is open.
    always_comb begin
        nxt_state = cur_state;
        timer_nxt = timer;
        row_nxt   = row;
        case (cur_state)
            BANK_IDLE: begin
                if (act) begin
                    nxt_state = BANK_ACTIVATING;
                    timer_nxt = TW'(TRCD - 1);
                    row_nxt   = row_in;
                end
            end
            BANK_ACTIVATING: begin
                if (pre) begin
                    nxt_state = BANK_PRECHARGING;
                    timer_nxt = TW'(TRP - 1);
                end else if (timer == '0) begin
                    nxt_state = BANK_ACTIVE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            BANK_ACTIVE: begin
                if (pre) begin
                    nxt_state = BANK_PRECHARGING;
                    timer_nxt = TW'(TRP - 1);
                end else if (act) begin
                    row_nxt = row_in;
                end
            end
            BANK_PRECHARGING: begin
                // A repeated PRE here is legal but must not restart tRP.
                if (timer == '0) begin
                    nxt_state = BANK_IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                nxt_state = BANK_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign state = cur_state;

endmodule

// File: rtl/sdr_cmd_monitor.sv
// sdr_cmd_monitor
// Passive monitor for an SDR SDRAM command bus. Decodes the sampled command pins,
// tracks every bank's open/closed state and timing, flags protocol violations in a
// sticky error vector, captures the MRS burst length / CAS latency and (optionally)
// counts ACT/READ/WRITE/AREF commands.
// Build option: define SDR_MON_CNT_EN to include the command counters; without it the
// counter outputs are tied to zero and no counter flops are built.
// Ports:
//   sdram_clk, sdram_resetn             : clock, asynchronous active-low reset
//   sdr_cs_n/ras_n/cas_n/we_n/cke       : sampled command pins
//   sdr_ba, sdr_addr                    : sampled bank and address
//   err_clr                             : clears the sticky error flags
//   bank_open[NB]                       : bank b is ACTIVE
//   open_row[NB*SDR_AW]                 : row latched per bank (bank b at b*SDR_AW)
//   err[6]                              : sticky violation flags (see ERR_* in package)
//   mode_bl, mode_cl                    : burst length / CAS latency from last MRS
//   act_cnt, rd_cnt, wr_cnt, ref_cnt    : saturating command counters
module sdr_cmd_monitor #(
    parameter int SDR_AW   = 13,
    parameter int SDR_BA_W = 2,
    parameter int TRCD     = 3,
    parameter int TRP      = 3,
    parameter int CNT_W    = 16
) (
    input  logic                             sdram_clk,
    input  logic                             sdram_resetn,
    input  logic                             sdr_cs_n,
    input  logic                             sdr_ras_n,
    input  logic                             sdr_cas_n,
    input  logic                             sdr_we_n,
    input  logic                             sdr_cke,
    input  logic [SDR_BA_W-1:0]              sdr_ba,
    input  logic [SDR_AW-1:0]                sdr_addr,
    input  logic                             err_clr,
    output logic [(2**SDR_BA_W)-1:0]         bank_open,
    output logic [(2**SDR_BA_W)*SDR_AW-1:0]  open_row,
    output logic [5:0]                       err,
    output logic [2:0]                       mode_bl,
    output logic [2:0]                       mode_cl,
    output logic [CNT_W-1:0]                 act_cnt,
    output logic [CNT_W-1:0]                 rd_cnt,
    output logic [CNT_W-1:0]                 wr_cnt,
    output logic [CNT_W-1:0]                 ref_cnt
);

    import sdr_mon_pkg::*;

    localparam int NB = 2**SDR_BA_W;

    sdr_cmd_e             cmd;
    logic                 is_rw;
    logic [NB-1:0]        bank_act;
    logic [NB-1:0]        bank_pre;
    logic [NB-1:0][1:0]   bank_st;
    logic [1:0]           tgt_st;
    logic                 all_idle;
    logic [ERR_W-1:0]     err_new;
    logic [ERR_W-1:0]     err_nxt;

    assign cmd   = decode_cmd(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
    assign is_rw = (cmd == CMD_READ) || (cmd == CMD_WRITE);

    // Fan the decoded command out to the banks. PRE with A10 high hits every bank.
    always_comb begin
        bank_act = '0;
        bank_pre = '0;
        for (int b = 0; b < NB; b++) begin
            bank_act[b] = (cmd == CMD_ACT) && (sdr_ba == SDR_BA_W'(b));
            bank_pre[b] = (cmd == CMD_PRE) && (sdr_addr[10] || (sdr_ba == SDR_BA_W'(b)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_bank
            sdr_mon_bank #(
                .SDR_AW (SDR_AW),
                .TRCD   (TRCD),
                .TRP    (TRP)
            ) u_bank (
                .clk    (sdram_clk),
                .rst_n  (sdram_resetn),
                .act    (bank_act[g]),
                .pre    (bank_pre[g]),
                .row_in (sdr_addr),
                .state  (bank_st[g]),
                .row    (open_row[g*SDR_AW +: SDR_AW])
            );
            assign bank_open[g] = (bank_st[g] == BANK_ACTIVE);
        end
    endgenerate

    // Violations are judged against the bank states before this edge, i.e. the
    // state the command actually found on the bus.
    always_comb begin
        tgt_st   = bank_st[sdr_ba];
        all_idle = 1'b1;
        for (int b = 0; b < NB; b++) begin
            if (bank_st[b] != BANK_IDLE) begin
                all_idle = 1'b0;
            end
        end
        err_new                = '0;
        err_new[ERR_ACT_OPEN]  = (cmd == CMD_ACT) && (tgt_st == BANK_ACTIVE);
        err_new[ERR_TRP]       = (cmd == CMD_ACT) && (tgt_st == BANK_PRECHARGING);
        err_new[ERR_TRCD]      = is_rw && (tgt_st == BANK_ACTIVATING);
        err_new[ERR_RW_CLOSED] = is_rw && ((tgt_st == BANK_IDLE) ||
                                           (tgt_st == BANK_PRECHARGING));
        err_new[ERR_AREF_OPEN] = (cmd == CMD_AREF) && !all_idle;
        err_new[ERR_MRS_OPEN]  = (cmd == CMD_MRS) && !all_idle;
        // A clear wins over old flags but never hides a violation seen the same cycle.
        err_nxt = err_clr ? err_new : (err | err_new);
    end

    // Sticky error flags and the mode register shadow.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            err     <= '0;
            mode_bl <= '0;
            mode_cl <= '0;
        end else begin
            err <= err_nxt;
            if (cmd == CMD_MRS) begin
                mode_bl <= sdr_addr[2:0];
                mode_cl <= sdr_addr[6:4];
            end
        end
    end

`ifdef SDR_MON_CNT_EN
    // Counters include erroneous commands and stick at all-ones instead of wrapping.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            act_cnt <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            ref_cnt <= '0;
        end else begin
            if ((cmd == CMD_ACT) && (act_cnt != '1)) begin
                act_cnt <= act_cnt + CNT_W'(1);
            end
            if ((cmd == CMD_READ) && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if ((cmd == CMD_WRITE) && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if ((cmd == CMD_AREF) && (ref_cnt != '1)) begin
                ref_cnt <= ref_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign act_cnt = '0;
    assign rd_cnt  = '0;
    assign wr_cnt  = '0;
    assign ref_cnt = '0;
`endif

endmodule
